// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage: access sizes,
// FSM encoding, bus timeout limit and the alignment rule.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } access_sz_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic [7:0] TIMEOUT_MAX = 8'd255;

    // The reserved size is treated as permanently misaligned so it never reaches the bus.
    function automatic logic is_aligned(input access_sz_e sz, input logic [1:0] offset);
        case (sz)
            SZ_BYTE: is_aligned = 1'b1;
            SZ_HALF: is_aligned = ~offset[0];
            SZ_WORD: is_aligned = (offset == 2'b00);
            default: is_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half lane out of a read word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  access_sz_e  size,
    input  logic [1:0]  offset,
    input  logic        zero_ext,
    output logic [31:0] data
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = lanes[offset];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        data     = rdata;
        case (size)
            SZ_BYTE: data = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{~zero_ext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data bus, stalls upstream on wait states,
// times out dead accesses and registers the write-back result.
module mem_access_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_plus_4_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  rd_addr_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    input  logic [1:0]  access_sz_in,
    input  logic        s_us_in,
    input  logic        jump_in,
    mem_access_stage_if.master dmem,
    output logic        stall,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        misalign_exc,
    output logic        bus_err
);

    state_e      state_reg, state_next;
    logic [7:0]  timeout_cnt_reg, timeout_cnt_next;
    logic [7:0]  timeout_cnt_inc;
    access_sz_e  sz;
    logic [1:0]  offset;
    logic        mem_op;
    logic        aligned;
    logic        timeout_hit;
    logic        misalign_now;
    logic        req;
    logic [31:0] load_data;
    logic [31:0] wb_data_next;

    assign sz              = access_sz_e'(access_sz_in);
    assign offset          = alu_result_in[1:0];
    assign mem_op          = mem_read_in | mem_write_in;
    assign aligned         = is_aligned(sz, offset);
    assign timeout_cnt_inc = timeout_cnt_reg + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            timeout_cnt_reg <= 8'd0;
        end else begin
            state_reg       <= state_next;
            timeout_cnt_reg <= timeout_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        timeout_cnt_next = timeout_cnt_reg;
        timeout_hit      = 1'b0;
        req              = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req = mem_op & aligned;
                if (mem_op && aligned && !dmem.dmem_ack) begin
                    state_next       = ST_ACCESS;
                    timeout_cnt_next = 8'd0;
                end
            end
            ST_ACCESS: begin
                req = 1'b1;
                if (dmem.dmem_ack) begin
                    state_next       = ST_IDLE;
                    timeout_cnt_next = 8'd0;
                end else if (timeout_cnt_inc == TIMEOUT_MAX) begin
                    // The IDLE request cycle counts as the first wait, so the stall spans TIMEOUT_MAX cycles.
                    timeout_hit      = 1'b1;
                    state_next       = ST_IDLE;
                    timeout_cnt_next = 8'd0;
                end else begin
                    timeout_cnt_next = timeout_cnt_inc;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        req = req & ~reset;
    end

    assign stall        = req & ~dmem.dmem_ack & ~timeout_hit;
    assign misalign_now = mem_op & ~aligned & (state_reg == ST_IDLE);

    assign dmem.dmem_req  = req;
    assign dmem.dmem_we   = req & mem_write_in;
    assign dmem.dmem_addr = {alu_result_in[31:2], 2'b00};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
            logic lane_hit;
            always_comb begin
                case (sz)
                    SZ_BYTE: lane_hit = (offset == gi[1:0]);
                    SZ_HALF: lane_hit = (offset[1] == gi[1]);
                    SZ_WORD: lane_hit = 1'b1;
                    default: lane_hit = 1'b0;
                endcase
            end
            assign dmem.dmem_be[gi] = req & mem_write_in & lane_hit;
            assign dmem.dmem_wdata[8*gi +: 8] =
                (sz == SZ_BYTE) ? rs2_data_in[7:0] :
                (sz == SZ_HALF) ? rs2_data_in[8*(gi%2) +: 8] :
                                  rs2_data_in[8*gi +: 8];
        end
    endgenerate

    load_align u_load_align (
        .rdata    (dmem.dmem_rdata),
        .size     (sz),
        .offset   (offset),
        .zero_ext (s_us_in),
        .data     (load_data)
    );

    always_comb begin
        wb_data_next = alu_result_in;
        if (jump_in)
            wb_data_next = pc_plus_4_in;
        else if (mem_to_reg_in)
            wb_data_next = load_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_rd_addr   <= 5'd0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'd0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_exc <= misalign_now;
            bus_err      <= timeout_hit;
            if (stall) begin
                wb_reg_write <= 1'b0;
            end else begin
                wb_rd_addr   <= rd_addr_in;
                wb_data      <= wb_data_next;
                wb_reg_write <= reg_write_in & ~misalign_now & ~timeout_hit;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, wait states, misalignment,
// bus timeout and reset during an access.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_plus_4_in;
    logic [31:0] alu_result_in;
    logic [31:0] rs2_data_in;
    logic [4:0]  rd_addr_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        mem_to_reg_in;
    logic [1:0]  access_sz_in;
    logic        s_us_in;
    logic        jump_in;
    logic        stall;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        misalign_exc;
    logic        bus_err;

    mem_access_stage_if dmem_bus ();

    mem_access_stage dut (
        .clk           (clk),
        .reset         (reset),
        .pc_plus_4_in  (pc_plus_4_in),
        .alu_result_in (alu_result_in),
        .rs2_data_in   (rs2_data_in),
        .rd_addr_in    (rd_addr_in),
        .reg_write_in  (reg_write_in),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .mem_to_reg_in (mem_to_reg_in),
        .access_sz_in  (access_sz_in),
        .s_us_in       (s_us_in),
        .jump_in       (jump_in),
        .dmem          (dmem_bus.master),
        .stall         (stall),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .misalign_exc  (misalign_exc),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Registered outputs are sampled 1 ns after the edge; combinational ones 2 ns after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_op();
        pc_plus_4_in  = 32'd0;
        alu_result_in = 32'd0;
        rs2_data_in   = 32'd0;
        rd_addr_in    = 5'd0;
        reg_write_in  = 1'b0;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        mem_to_reg_in = 1'b0;
        access_sz_in  = 2'b00;
        s_us_in       = 1'b0;
        jump_in       = 1'b0;
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'd0;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [1:0] sz,
                            input logic us, input logic [4:0] rd);
        clear_op();
        alu_result_in = addr;
        access_sz_in  = sz;
        s_us_in       = us;
        rd_addr_in    = rd;
        mem_read_in   = 1'b1;
        mem_to_reg_in = 1'b1;
        reg_write_in  = 1'b1;
    endtask

    task automatic set_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
        clear_op();
        alu_result_in = addr;
        access_sz_in  = sz;
        rs2_data_in   = data;
        mem_write_in  = 1'b1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [31:0] data;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } store_vec_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        us;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_data;
    } load_vec_t;

    store_vec_t stores [3];
    load_vec_t  loads  [5];

    initial begin
        int stall_cycles;

        stores[0] = '{"SH 0x202", 32'h0000_0202, 2'b01, 32'h0000_ABCD, 32'hABCD_ABCD, 4'b1100};
        stores[1] = '{"SB 0x101", 32'h0000_0101, 2'b00, 32'h0000_0012, 32'h1212_1212, 4'b0010};
        stores[2] = '{"SW 0x300", 32'h0000_0300, 2'b10, 32'h1234_5678, 32'h1234_5678, 4'b1111};

        loads[0] = '{"LW 0x100",  32'h0000_0100, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
        loads[1] = '{"LB 0x103",  32'h0000_0103, 2'b00, 1'b0, 32'h80FF_FFFF, 3, 32'hFFFF_FF80};
        loads[2] = '{"LBU 0x103", 32'h0000_0103, 2'b00, 1'b1, 32'h80FF_FFFF, 3, 32'h0000_0080};
        loads[3] = '{"LH 0x102",  32'h0000_0102, 2'b01, 1'b0, 32'hF00D_1234, 1, 32'hFFFF_F00D};
        loads[4] = '{"LHU 0x100", 32'h0000_0100, 2'b01, 1'b1, 32'h0000_8765, 0, 32'h0000_8765};

        reset = 1'b1;
        clear_op();
        tick();
        tick();
        reset = 1'b0;
        settle();
        $display("txn reset released");
        check("rst wb_rd_addr",   32'(wb_rd_addr), 32'd0);
        check("rst wb_reg_write", 32'(wb_reg_write), 32'd0);
        check("rst wb_data",      wb_data, 32'd0);
        check("rst misalign_exc", 32'(misalign_exc), 32'd0);
        check("rst bus_err",      32'(bus_err), 32'd0);
        check("rst dmem_req",     32'(dmem_bus.dmem_req), 32'd0);
        check("rst stall",        32'(stall), 32'd0);

        // Loads with a varying number of wait states before ack
        foreach (loads[i]) begin
            tick();
            set_load(loads[i].addr, loads[i].sz, loads[i].us, 5'd5 + 5'(i));
            dmem_bus.dmem_rdata = loads[i].rdata;
            $display("txn %s waits=%0d rdata=0x%08h", loads[i].name, loads[i].waits, loads[i].rdata);
            for (int w = 0; w < loads[i].waits; w++) begin
                settle();
                check({loads[i].name, " stall"}, 32'(stall), 32'd1);
                check({loads[i].name, " req wait"}, 32'(dmem_bus.dmem_req), 32'd1);
                tick();
                check({loads[i].name, " wb_we during stall"}, 32'(wb_reg_write), 32'd0);
            end
            dmem_bus.dmem_ack = 1'b1;
            settle();
            check({loads[i].name, " req"},  32'(dmem_bus.dmem_req), 32'd1);
            check({loads[i].name, " we"},   32'(dmem_bus.dmem_we), 32'd0);
            check({loads[i].name, " addr"}, dmem_bus.dmem_addr, {loads[i].addr[31:2], 2'b00});
            check({loads[i].name, " be"},   32'(dmem_bus.dmem_be), 32'd0);
            check({loads[i].name, " stall on ack"}, 32'(stall), 32'd0);
            tick();
            clear_op();
            check({loads[i].name, " wb_data"},      wb_data, loads[i].exp_data);
            check({loads[i].name, " wb_reg_write"}, 32'(wb_reg_write), 32'd1);
            check({loads[i].name, " wb_rd_addr"},   32'(wb_rd_addr), 32'd5 + 32'(i));
        end

        foreach (stores[i]) begin
            tick();
            set_store(stores[i].addr, stores[i].sz, stores[i].data);
            dmem_bus.dmem_ack = 1'b1;
            settle();
            $display("txn %s data=0x%08h", stores[i].name, stores[i].data);
            check({stores[i].name, " req"},   32'(dmem_bus.dmem_req), 32'd1);
            check({stores[i].name, " we"},    32'(dmem_bus.dmem_we), 32'd1);
            check({stores[i].name, " addr"},  dmem_bus.dmem_addr, {stores[i].addr[31:2], 2'b00});
            check({stores[i].name, " wdata"}, dmem_bus.dmem_wdata, stores[i].exp_wdata);
            check({stores[i].name, " be"},    32'(dmem_bus.dmem_be), 32'(stores[i].exp_be));
            check({stores[i].name, " stall"}, 32'(stall), 32'd0);
        end

        // ALU result pass-through with a stray ack that must be ignored
        tick();
        clear_op();
        alu_result_in = 32'h0000_1234;
        rd_addr_in    = 5'd9;
        reg_write_in  = 1'b1;
        dmem_bus.dmem_ack = 1'b1;
        settle();
        $display("txn ALU pass-through with stray ack");
        check("alu req", 32'(dmem_bus.dmem_req), 32'd0);
        check("alu stall", 32'(stall), 32'd0);
        tick();
        clear_op();
        pc_plus_4_in  = 32'h0000_0044;
        alu_result_in = 32'h0000_0999;
        mem_to_reg_in = 1'b1;
        jump_in       = 1'b1;
        reg_write_in  = 1'b1;
        rd_addr_in    = 5'd1;
        check("alu wb_data", wb_data, 32'h0000_1234);
        check("alu wb_rd_addr", 32'(wb_rd_addr), 32'd9);
        $display("txn jump link");
        tick();
        clear_op();
        check("jump wb_data", wb_data, 32'h0000_0044);
        check("jump wb_reg_write", 32'(wb_reg_write), 32'd1);

        // Misaligned word load and reserved size
        set_load(32'h0000_0101, 2'b10, 1'b0, 5'd3);
        settle();
        $display("txn LW 0x101 misaligned");
        check("mis req", 32'(dmem_bus.dmem_req), 32'd0);
        check("mis stall", 32'(stall), 32'd0);
        tick();
        clear_op();
        check("mis exc", 32'(misalign_exc), 32'd1);
        check("mis wb_reg_write", 32'(wb_reg_write), 32'd0);
        tick();
        check("mis exc pulse end", 32'(misalign_exc), 32'd0);
        set_load(32'h0000_0100, 2'b11, 1'b0, 5'd3);
        settle();
        $display("txn reserved size load");
        check("rsvd req", 32'(dmem_bus.dmem_req), 32'd0);
        tick();
        clear_op();
        check("rsvd exc", 32'(misalign_exc), 32'd1);

        // Word load that is never acknowledged
        tick();
        set_load(32'h0000_0400, 2'b10, 1'b0, 5'd7);
        settle();
        $display("txn LW 0x400 without ack");
        stall_cycles = 0;
        while (stall && stall_cycles < 400) begin
            stall_cycles++;
            tick();
            settle();
        end
        check("timeout stall cycles", 32'(stall_cycles), 32'd255);
        check("timeout req on hit", 32'(dmem_bus.dmem_req), 32'd1);
        tick();
        clear_op();
        check("timeout bus_err", 32'(bus_err), 32'd1);
        check("timeout wb_reg_write", 32'(wb_reg_write), 32'd0);
        settle();
        check("timeout req after", 32'(dmem_bus.dmem_req), 32'd0);
        tick();
        check("timeout bus_err pulse end", 32'(bus_err), 32'd0);

        // Reset in the second ACCESS cycle, then a late ack
        set_load(32'h0000_0500, 2'b10, 1'b0, 5'd11);
        dmem_bus.dmem_rdata = 32'hCAFE_F00D;
        $display("txn LW 0x500 reset mid-access");
        tick();
        tick();
        settle();
        check("rstacc stall", 32'(stall), 32'd1);
        reset = 1'b1;
        clear_op();
        tick();
        reset = 1'b0;
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'hCAFE_F00D;
        settle();
        check("rstacc req", 32'(dmem_bus.dmem_req), 32'd0);
        check("rstacc stall after", 32'(stall), 32'd0);
        tick();
        clear_op();
        check("rstacc wb_reg_write", 32'(wb_reg_write), 32'd0);
        check("rstacc wb_data", wb_data, 32'd0);
        check("rstacc wb_rd_addr", 32'(wb_rd_addr), 32'd0);
        check("rstacc bus_err", 32'(bus_err), 32'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge; reset  in  1  synchronous, active-high.
REQ-002 SHALL have inputs from EX/MEM: pc_plus_4_in 32, alu_result_in 32 (address or result), rs2_data_in 32 (store data), rd_addr_in 5, reg_write_in 1, mem_read_in 1, mem_write_in 1, mem_to_reg_in 1, access_sz_in 2 (00 byte, 01 half, 10 word, 11 reserved), s_us_in 1 (1 = zero-extend load), jump_in 1.
REQ-003 SHALL have data-bus ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32 (word-aligned), dmem_wdata out 32, dmem_be out 4, dmem_rdata in 32, dmem_ack in 1.
REQ-004 SHALL have outputs: stall out 1 (hold upstream stages), wb_rd_addr out 5, wb_reg_write out 1, wb_data out 32, misalign_exc out 1 (one-cycle pulse), bus_err out 1 (one-cycle pulse).

Function
REQ-005 mem_op = mem_read_in | mem_write_in; an op is aligned when: byte always; half needs addr[0]=0; word needs addr[1:0]=00; size 11 is never aligned.
REQ-006 FSM states IDLE, ACCESS; reset state IDLE.
REQ-007 dmem_req SHALL be high in IDLE when mem_op and aligned, and throughout ACCESS; low otherwise.
REQ-008 dmem_we = mem_write_in while dmem_req; dmem_addr = {alu_result_in[31:2], 2'b00}.
REQ-009 Store: byte replicated to all lanes, be = 0001 shifted by addr[1:0]; half replicated, be = 0011 or 1100 by addr[1]; word be = 1111; be = 0000 for loads.
REQ-010 IDLE + aligned op + dmem_ack same cycle: zero-wait completion, stall low, stay IDLE.
REQ-011 IDLE + aligned op + no ack: stall high, go ACCESS, timeout counter cleared.
REQ-012 ACCESS: stall high until dmem_ack; on ack stall low that cycle, result captured, go IDLE.
REQ-013 Stall SHALL equal mem_op & aligned & ~dmem_ack & ~timeout_hit; upstream inputs are stable while stall is high.
REQ-014 8-bit timeout counter increments each ACCESS cycle without ack; at count 255 without ack: bus_err pulse, stall low, wb_reg_write 0 next cycle, go IDLE, counter 0.
REQ-015 Misaligned op: no dmem_req, stall low, misalign_exc pulses next cycle, wb_reg_write 0.
REQ-016 Load data: select lane by addr[1:0] (byte) or addr[1] (half); sign-extend if s_us_in=0, zero-extend if 1.
REQ-017 wb_data priority: jump_in -> pc_plus_4_in; else mem_to_reg_in -> load data; else alu_result_in.
REQ-018 WB outputs SHALL register on each cycle stall is low (latency 1 cycle after completion); while stall is high wb_reg_write SHALL be 0.
REQ-019 dmem_ack in IDLE with no aligned op SHALL be ignored.

Reset
REQ-020 reset SHALL force IDLE, counter 0, wb_rd_addr 0, wb_reg_write 0, wb_data 0, misalign_exc 0, bus_err 0; dmem_req and stall are 0 in the cycle after reset.
REQ-021 reset during ACCESS SHALL abandon the access with no write-back; any late ack is ignored per REQ-019.

Structure
REQ-022 Shared package mem_pkg SHALL hold access-size encodings, FSM state encoding and TIMEOUT_MAX = 255.
REQ-023 Load lane extraction and extension SHALL be a combinational sub-module load_align.

Verification
REQ-024 LW addr 0x100, ack same cycle, rdata 0xDEADBEEF -> no stall; next cycle wb_data 0xDEADBEEF, wb_reg_write 1.
REQ-025 LB signed addr 0x103, rdata 0x80FFFFFF, ack after 3 cycles -> stall high 3 cycles; wb_data 0xFFFFFF80. LBU with the same stimulus -> 0x00000080.
REQ-026 SH addr 0x202, rs2 0x0000ABCD -> dmem_wdata 0xABCDABCD, be 1100, we 1, addr 0x200.
REQ-027 LW addr 0x101 -> no dmem_req, misalign_exc pulse, wb_reg_write 0.
REQ-028 LW with ack never returned -> stall high for 255 cycles, then bus_err pulse, stall low, no write-back.
REQ-029 reset asserted in 2nd ACCESS cycle, then ack -> IDLE, dmem_req 0, ack ignored, all WB outputs 0.
